// File: rtl/i2c_bridge_pkg.sv
// ============================================================================
// Module      : i2c_bridge_pkg
// Description : Shared encodings for the UART-to-I2C frame bridge: I2C master
//               commands, response status codes and FSM state encodings.
// Revision    : 1.0 - initial frame-level bridge
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package i2c_bridge_pkg;

    localparam logic [2:0] c_cmd_start     = 3'd0;
    localparam logic [2:0] c_cmd_write     = 3'd1;
    localparam logic [2:0] c_cmd_read_ack  = 3'd2;
    localparam logic [2:0] c_cmd_read_nack = 3'd3;
    localparam logic [2:0] c_cmd_stop      = 3'd4;

    localparam logic [7:0] c_st_ok        = 8'h00;
    localparam logic [7:0] c_st_addr_nack = 8'h01;
    localparam logic [7:0] c_st_data_nack = 8'h02;
    localparam logic [7:0] c_st_bad_len   = 8'h03;
    localparam logic [7:0] c_st_timeout   = 8'h04;

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_GET_LEN = 4'd1,
        S_START   = 4'd2,
        S_ADDR    = 4'd3,
        S_W_WAIT  = 4'd4,
        S_W_SEND  = 4'd5,
        S_RD      = 4'd6,
        S_STOP    = 4'd7,
        S_STAT    = 4'd8,
        S_CHK     = 4'd9
    } bridge_state_t;

    typedef enum logic [1:0] {
        D_IDLE = 2'd0,
        D_HI   = 2'd1,
        D_LO   = 2'd2
    } drain_state_t;

endpackage

`default_nettype wire

// File: rtl/byte_fifo.sv
// ============================================================================
// Module      : byte_fifo
// Description : Synchronous show-ahead FIFO; simultaneous push and pop are
//               both honoured, a push while full is dropped.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module byte_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 32
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   i_push,
    input  logic [WIDTH-1:0]       i_push_data,
    input  logic                   i_pop,
    output logic [WIDTH-1:0]       o_pop_data,
    output logic                   o_full,
    output logic                   o_empty,
    output logic [$clog2(DEPTH):0] o_count
);

    localparam int c_aw = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_aw-1:0]  r_wr_ptr;
    logic [c_aw-1:0]  r_rd_ptr;
    logic [c_aw:0]    r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_empty    = (r_count == '0);
    assign o_full     = (r_count == (c_aw+1)'(DEPTH));
    assign o_count    = r_count;
    assign o_pop_data = r_mem[r_rd_ptr];
    assign w_do_pop   = i_pop && !o_empty;
    assign w_do_push  = i_push && (!o_full || w_do_pop);

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + c_aw'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + c_aw'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + (c_aw+1)'(1);
                2'b01:   r_count <= r_count - (c_aw+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset_n) begin
            assert (!(i_push && !w_do_push))
                else $error("byte_fifo: push while full dropped");
        end
    end

endmodule

`default_nettype wire

// File: rtl/i2c_uart_bridge.sv
// ============================================================================
// Module      : i2c_uart_bridge
// Description : Parses UART frames into multi-byte I2C bursts and returns a
//               status byte plus read data. Optional checksum byte per
//               response when I2C_UART_BRIDGE_CHKSUM_EN is defined.
// Revision    : 1.0 - successor to the single-byte strobe controller
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module i2c_uart_bridge
    import i2c_bridge_pkg::*;
#(
    parameter int MAX_LEN     = 16,
    parameter int TXF_DEPTH   = 32,
    parameter int TIMEOUT_CYC = 100000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       rx_valid,
    input  logic [7:0] rx_data,
    input  logic       tx_busy,
    output logic       tx_start,
    output logic [7:0] tx_data,
    output logic       i2c_cmd_valid,
    input  logic       i2c_cmd_ready,
    output logic [2:0] i2c_cmd,
    output logic [7:0] i2c_wdata,
    input  logic       i2c_rsp_valid,
    input  logic       i2c_rsp_ack,
    input  logic [7:0] i2c_rdata,
    output logic       busy,
    output logic [7:0] err_cnt
);

    localparam logic [7:0]        c_max_len = 8'(MAX_LEN);
    localparam int                c_to_w    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [c_to_w-1:0] c_to_max  = c_to_w'(TIMEOUT_CYC);

    bridge_state_t r_state;
    drain_state_t  r_drain;
    logic          r_rw;
    logic [6:0]    r_addr;
    logic [7:0]    r_rem;
    logic [7:0]    r_wbyte;
    logic [7:0]    r_status;
    logic          r_stat_pend;
    logic [7:0]    r_drop_cnt;
    logic          r_wait_rsp;
    logic          r_push;
    logic          r_push_stat;
    logic [7:0]    r_push_data;
    logic [c_to_w-1:0] r_to_cnt;

    logic       w_rx;
    logic       w_rx_drop;
    logic       w_timeout;
    logic       w_rsp;
    logic       w_to_run;
    logic       w_cmd_state;
    logic [2:0] w_cmd_sel;
    logic [7:0] w_wdata_sel;
    logic       w_pop;
    logic [7:0] w_fifo_rdata;
    logic       w_fifo_full;
    logic       w_fifo_empty;
    logic [$clog2(TXF_DEPTH):0] w_fifo_count;
    logic       w_unused;

`ifdef I2C_UART_BRIDGE_CHKSUM_EN
    localparam bridge_state_t c_resp_end = S_CHK;
    logic [7:0] r_xor;
    logic [7:0] w_xor_next;

    // Includes a push landing this very cycle so the checksum never lags.
    assign w_xor_next = r_xor ^ (r_push ? r_push_data : 8'h00);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_xor <= 8'h00;
        end else if (r_state == S_IDLE && w_rx) begin
            r_xor <= 8'h00;
        end else begin
            r_xor <= w_xor_next;
        end
    end
`else
    localparam bridge_state_t c_resp_end = S_IDLE;
`endif

    assign w_rx      = rx_valid && (r_drop_cnt == 8'd0);
    assign w_rx_drop = rx_valid && (r_drop_cnt != 8'd0);
    assign w_timeout = (r_to_cnt == c_to_max);
    assign w_rsp     = r_wait_rsp && i2c_rsp_valid;
    assign w_to_run  = (r_state == S_GET_LEN) || (r_state == S_W_WAIT);
    assign busy      = (r_state != S_IDLE);
    assign w_unused  = ^{w_fifo_full, w_fifo_count};

    always_comb begin
        w_cmd_state = 1'b1;
        w_cmd_sel   = c_cmd_start;
        w_wdata_sel = r_wbyte;
        case (r_state)
            S_START:  w_cmd_sel = c_cmd_start;
            S_ADDR: begin
                w_cmd_sel   = c_cmd_write;
                w_wdata_sel = {r_addr, r_rw};
            end
            S_W_SEND: w_cmd_sel = c_cmd_write;
            S_RD:     w_cmd_sel = (r_rem == 8'd1) ? c_cmd_read_nack : c_cmd_read_ack;
            S_STOP:   w_cmd_sel = c_cmd_stop;
            default:  w_cmd_state = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n || rx_valid || !w_to_run) begin
            r_to_cnt <= '0;
        end else if (!w_timeout) begin
            r_to_cnt <= r_to_cnt + c_to_w'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state       <= S_IDLE;
            r_rw          <= 1'b0;
            r_addr        <= 7'd0;
            r_rem         <= 8'd0;
            r_wbyte       <= 8'd0;
            r_status      <= 8'd0;
            r_stat_pend   <= 1'b0;
            r_drop_cnt    <= 8'd0;
            r_wait_rsp    <= 1'b0;
            r_push        <= 1'b0;
            r_push_stat   <= 1'b0;
            r_push_data   <= 8'd0;
            i2c_cmd_valid <= 1'b0;
            i2c_cmd       <= c_cmd_start;
            i2c_wdata     <= 8'd0;
        end else begin
            r_push      <= 1'b0;
            r_push_stat <= 1'b0;
            if (w_rx_drop) begin
                r_drop_cnt <= r_drop_cnt - 8'd1;
            end

            // Every command state shares one issue/accept/response sequence.
            if (w_cmd_state && !i2c_cmd_valid && !r_wait_rsp) begin
                i2c_cmd_valid <= 1'b1;
                i2c_cmd       <= w_cmd_sel;
                i2c_wdata     <= w_wdata_sel;
            end else if (i2c_cmd_valid && i2c_cmd_ready) begin
                i2c_cmd_valid <= 1'b0;
                r_wait_rsp    <= 1'b1;
            end else if (w_rsp) begin
                r_wait_rsp <= 1'b0;
            end

            case (r_state)
                S_IDLE: begin
                    if (w_rx) begin
                        r_rw    <= rx_data[7];
                        r_addr  <= rx_data[6:0];
                        r_state <= S_GET_LEN;
                    end
                end
                S_GET_LEN: begin
                    if (w_rx) begin
                        if (rx_data == 8'd0 || rx_data > c_max_len) begin
                            r_push      <= 1'b1;
                            r_push_stat <= 1'b1;
                            r_push_data <= c_st_bad_len;
                            r_state     <= c_resp_end;
                        end else begin
                            r_rem   <= rx_data;
                            r_state <= S_START;
                        end
                    end else if (w_timeout) begin
                        r_push      <= 1'b1;
                        r_push_stat <= 1'b1;
                        r_push_data <= c_st_timeout;
                        r_state     <= c_resp_end;
                    end
                end
                S_START: begin
                    if (w_rsp) begin
                        r_state <= S_ADDR;
                    end
                end
                S_ADDR: begin
                    if (w_rsp) begin
                        if (!i2c_rsp_ack) begin
                            r_status    <= c_st_addr_nack;
                            r_stat_pend <= 1'b1;
                            r_drop_cnt  <= r_rw ? 8'd0 : r_rem;
                            r_state     <= S_STOP;
                        end else if (r_rw) begin
                            r_push      <= 1'b1;
                            r_push_stat <= 1'b1;
                            r_push_data <= c_st_ok;
                            r_state     <= S_RD;
                        end else begin
                            r_state <= S_W_WAIT;
                        end
                    end
                end
                S_W_WAIT: begin
                    if (w_rx) begin
                        r_wbyte <= rx_data;
                        r_state <= S_W_SEND;
                    end else if (w_timeout) begin
                        r_status    <= c_st_timeout;
                        r_stat_pend <= 1'b1;
                        r_state     <= S_STOP;
                    end
                end
                S_W_SEND: begin
                    if (w_rsp) begin
                        if (i2c_rsp_ack) begin
                            r_rem <= r_rem - 8'd1;
                            if (r_rem == 8'd1) begin
                                r_status    <= c_st_ok;
                                r_stat_pend <= 1'b1;
                                r_state     <= S_STOP;
                            end else begin
                                r_state <= S_W_WAIT;
                            end
                        end else begin
                            r_status    <= c_st_data_nack;
                            r_stat_pend <= 1'b1;
                            r_drop_cnt  <= r_rem - 8'd1;
                            r_state     <= S_STOP;
                        end
                    end
                end
                S_RD: begin
                    if (w_rsp) begin
                        r_push      <= 1'b1;
                        r_push_data <= i2c_rdata;
                        r_rem       <= r_rem - 8'd1;
                        if (r_rem == 8'd1) begin
                            r_state <= S_STOP;
                        end
                    end
                end
                S_STOP: begin
                    if (w_rsp) begin
                        r_state <= S_STAT;
                    end
                end
                S_STAT: begin
                    if (r_stat_pend) begin
                        r_push      <= 1'b1;
                        r_push_stat <= 1'b1;
                        r_push_data <= r_status;
                        r_stat_pend <= 1'b0;
                    end
                    r_state <= c_resp_end;
                end
`ifdef I2C_UART_BRIDGE_CHKSUM_EN
                S_CHK: begin
                    r_push      <= 1'b1;
                    r_push_data <= w_xor_next;
                    r_state     <= S_IDLE;
                end
`endif
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            err_cnt <= 8'd0;
        end else if (r_push && r_push_stat && r_push_data != 8'd0 && err_cnt != 8'hFF) begin
            err_cnt <= err_cnt + 8'd1;
        end
    end

    byte_fifo #(
        .WIDTH (8),
        .DEPTH (TXF_DEPTH)
    ) u_txf (
        .clk         (clk),
        .reset_n     (reset_n),
        .i_push      (r_push),
        .i_push_data (r_push_data),
        .i_pop       (w_pop),
        .o_pop_data  (w_fifo_rdata),
        .o_full      (w_fifo_full),
        .o_empty     (w_fifo_empty),
        .o_count     (w_fifo_count)
    );

    assign w_pop = (r_drain == D_IDLE) && !w_fifo_empty && !tx_busy;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_drain  <= D_IDLE;
            tx_start <= 1'b0;
            tx_data  <= 8'd0;
        end else begin
            tx_start <= 1'b0;
            case (r_drain)
                D_IDLE: begin
                    if (w_pop) begin
                        tx_start <= 1'b1;
                        tx_data  <= w_fifo_rdata;
                        r_drain  <= D_HI;
                    end
                end
                D_HI:    if (tx_busy)  r_drain <= D_LO;
                D_LO:    if (!tx_busy) r_drain <= D_IDLE;
                default: r_drain <= D_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire
